// File: rtl/unsaved_led_pattern_driver_pkg.sv
// rtl/unsaved_led_pattern_driver_pkg.sv - mode codes and breathe direction for the LED pattern driver
package unsaved_led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/unsaved_tick_gen.sv
// rtl/unsaved_tick_gen.sv - prescaler producing a registered one-cycle tick per wrap
module unsaved_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_cnt;

  // clear beats the wrap so a restarting pattern never sees a stale tick
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else if (clear) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else if (presc_cnt == PRESC_LAST) begin
      presc_cnt <= '0;
      tick      <= 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
      tick      <= 1'b0;
    end
  end

endmodule

// File: rtl/unsaved_led_pattern_driver.sv
// rtl/unsaved_led_pattern_driver.sv - turns the 2-bit PIO mode code into off/on/blink/breathe LED drive
module unsaved_led_pattern_driver
  import unsaved_led_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode_in,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode_active,
  output logic                tick
);

  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

  logic                mode_chg;
  logic [BW-1:0]       blink_cnt;
  logic                blink_state;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  dir_t                dir;
  logic [NUM_LEDS-1:0] led_next;

  assign mode_chg = (mode_in != mode_active);

  unsaved_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(mode_chg),
    .tick (tick)
  );

  always_comb begin
    led_next = '0;
    case (mode_active)
      MODE_ON:      led_next = '1;
      MODE_BLINK:   led_next = {NUM_LEDS{blink_state}};
      MODE_BREATHE: led_next = {NUM_LEDS{pwm_cnt < duty}};
      default:      led_next = '0;
    endcase
  end

  // pattern state runs in every mode; a mode change restarts it from a known point
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active <= MODE_OFF;
      led         <= '0;
      blink_cnt   <= '0;
      blink_state <= 1'b0;
      pwm_cnt     <= '0;
      duty        <= '0;
      dir         <= DIR_UP;
    end else begin
      mode_active <= mode_in;
      led         <= led_next;
      if (mode_chg) begin
        blink_cnt   <= '0;
        blink_state <= 1'b1;
        pwm_cnt     <= '0;
        duty        <= '0;
        dir         <= DIR_UP;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (tick) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_state <= ~blink_state;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
          // direction flips on the same tick that reaches the end stop
          if (dir == DIR_UP) begin
            duty <= duty + 1'b1;
            if (duty == DUTY_MAX - DUTY_ONE) dir <= DIR_DOWN;
          end else begin
            duty <= duty - 1'b1;
            if (duty == DUTY_ONE) dir <= DIR_UP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_unsaved_led_pattern_driver.sv
// tb/tb_unsaved_led_pattern_driver.sv - self-checking bench with closed-form pattern model
module tb_unsaved_led_pattern_driver;

  localparam int P  = 4;
  localparam int BT = 3;
  localparam int PB = 3;
  localparam int NL = 4;
  localparam int M  = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode_in = 2'b00;
  logic [NL-1:0] led;
  logic [1:0]    mode_active;
  logic          tick;

  always #5 clk = ~clk;

  unsaved_led_pattern_driver #(
    .NUM_LEDS   (NL),
    .PRESCALE   (P),
    .BLINK_TICKS(BT),
    .PWM_BITS   (PB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_in    (mode_in),
    .led        (led),
    .mode_active(mode_active),
    .tick       (tick)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k = edges since the last restart; everything else follows from k
  function automatic logic [NL-1:0] led_of(input logic [1:0] md, input int k, input logic binit);
    int n, r, duty;
    logic bs;
    n = (k >= 1) ? (k - 1) / P : 0;
    case (md)
      2'b01: return '1;
      2'b10: begin
        bs = binit ^ (((n / BT) % 2) == 1);
        return {NL{bs}};
      end
      2'b11: begin
        r    = n % (2 * M);
        duty = (r <= M) ? r : 2 * M - r;
        return {NL{(k % (1 << PB)) < duty}};
      end
      default: return '0;
    endcase
  endfunction

  logic [1:0]    m_mode = 2'b00;
  int            m_k = 0;
  logic          m_binit = 1'b0;
  logic [NL-1:0] m_led = '0;
  logic          m_tick = 1'b0;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_led   = '0;
      m_mode  = 2'b00;
      m_k     = 0;
      m_binit = 1'b0;
      m_tick  = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_led = led_of(m_mode, m_k, m_binit);
      if (mode_in != m_mode) begin
        m_k     = 0;
        m_binit = 1'b1;
      end else begin
        m_k++;
      end
      m_mode = mode_in;
      m_tick = (m_k > 0) && (m_k % P == 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_led", led, m_led);
      check("model_mode_active", mode_active, m_mode);
      check("model_tick", tick, m_tick);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [NL-1:0] hist [1:64];
  logic [12:0]   th;
  logic [4:0]    th5;

  task automatic record(input int cnt);
    for (int e = 1; e <= cnt; e++) begin
      cyc();
      hist[e] = led;
    end
  endtask

  initial begin
    reset = 1'b1;
    mode_in = 2'b00;
    cyc();
    cyc();
    check("reset_led", led, 0);
    check("reset_mode_active", mode_active, 0);
    check("reset_tick", tick, 0);
    reset = 1'b0;

    th = '0;
    for (int j = 1; j <= 13; j++) begin
      cyc();
      th[j-1] = tick;
    end
    check("tick_every_4", th, 13'h888);

    mode_in = 2'b01;
    cyc();
    check("on_mode_lat", mode_active, 1);
    check("on_led_lat1", led, 0);
    cyc();
    check("on_led_lat2", led, 4'hF);
    mode_in = 2'b00;
    cyc();
    check("off_led_lat1", led, 4'hF);
    cyc();
    check("off_led_lat2", led, 0);

    mode_in = 2'b10;
    record(40);
    check("blink_e1", hist[1], 0);
    check("blink_e2", hist[2], 4'hF);
    check("blink_e14", hist[14], 4'hF);
    check("blink_e15", hist[15], 0);
    check("blink_e26", hist[26], 0);
    check("blink_e27", hist[27], 4'hF);
    check("blink_e38", hist[38], 4'hF);
    check("blink_e39", hist[39], 0);

    mode_in = 2'b11;
    record(62);
    for (int e = 2; e <= 6; e++) check("breathe_duty0_start", hist[e], 0);
    check("breathe_d3_e15", hist[15], 0);
    check("breathe_d3_e17", hist[17], 0);
    check("breathe_d3_e18", hist[18], 4'hF);
    check("breathe_d7_e31", hist[31], 4'hF);
    check("breathe_d7_e33", hist[33], 0);
    check("breathe_d7_e34", hist[34], 4'hF);
    check("breathe_d5_down", hist[42], 4'hF);
    check("breathe_d1_down", hist[58], 4'hF);
    for (int e = 59; e <= 62; e++) check("breathe_duty0_end", hist[e], 0);

    mode_in = 2'b01;
    for (int e = 1; e <= 4; e++) cyc();
    mode_in = 2'b10;
    for (int e = 0; e < 5; e++) begin
      cyc();
      th5[e] = tick;
    end
    check("chg_at_wrap_ticks", th5, 5'b10000);

    mode_in = 2'b11;
    for (int e = 1; e <= 39; e++) cyc();
    reset = 1'b1;
    cyc();
    check("midrst_led", led, 0);
    check("midrst_mode_active", mode_active, 0);
    check("midrst_tick", tick, 0);
    reset = 1'b0;
    cyc();
    check("post_rst_mode", mode_active, 3);
    check("post_rst_led1", led, 0);
    cyc();
    check("post_rst_led2", led, 0);
    for (int e = 1; e <= 24; e++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
